// File: rtl/kbd_line_buffer.sv
// kbd_line_buffer: editable ASCII line (backspace, commit on enter, ack/clear release) with flat view, length/full, drop pulse and registered read port
module kbd_line_buffer #(
  parameter int MAX_LEN = 16,
  parameter int AW = $clog2(MAX_LEN),
  parameter int LW = $clog2(MAX_LEN + 1)
) (
  input  logic                 clock_27mhz,
  input  logic                 reset,
  input  logic [7:0]           ascii,
  input  logic                 ascii_ready,
  input  logic                 line_ack,
  input  logic                 clear,
  input  logic [AW-1:0]        rd_addr,
  output logic [7:0]           rd_data,
  output logic [8*MAX_LEN-1:0] line_flat,
  output logic [LW-1:0]        length,
  output logic                 line_valid,
  output logic                 full,
  output logic                 dropped
);
  typedef enum logic {EDIT, DONE} state_t;
  state_t state, state_next;
  logic [7:0] chars [MAX_LEN];
  logic printable, is_bs, is_enter, nonempty, wipe, push, pop, drop;
  logic [AW-1:0] wr_idx;
  assign printable = ascii >= 8'h20 && ascii <= 8'h5f && ascii != 8'h23;
  assign is_bs = ascii == 8'h08;
  assign is_enter = ascii == 8'h0d;
  assign nonempty = length != '0;
  assign full = length == LW'(MAX_LEN);
  always_ff @(posedge clock_27mhz)
    state <= reset ? EDIT : state_next;
  always_comb
    state_next = state == EDIT ? (ascii_ready && is_enter && nonempty && !clear ? DONE : EDIT)
                               : (line_ack || clear ? EDIT : DONE);
  always_comb begin
    line_valid = state == DONE;
    wipe = state == EDIT ? clear : line_ack || clear;
    push = state == EDIT && !clear && ascii_ready && printable && !full;
    pop = state == EDIT && !clear && ascii_ready && is_bs && nonempty;
    drop = ascii_ready && printable && (state == DONE || (!clear && full));
    wr_idx = push ? AW'(length) : AW'(length - LW'(1));
    for (int i = 0; i < MAX_LEN; i++) line_flat[8*i +: 8] = chars[i];
  end
  always_ff @(posedge clock_27mhz)
    if (reset) begin
      chars <= '{default: 8'h20};
      length <= '0;
      dropped <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      dropped <= drop;
      rd_data <= 32'(rd_addr) < MAX_LEN ? chars[rd_addr] : 8'h20;
      if (wipe) begin
        chars <= '{default: 8'h20};
        length <= '0;
      end else if (push) begin
        chars[wr_idx] <= ascii;
        length <= length + LW'(1);
      end else if (pop) begin
        chars[wr_idx] <= 8'h20;
        length <= length - LW'(1);
      end
    end
endmodule

// File: doc/kbd_line_buffer.md
# kbd_line_buffer

Line-entry stage directly downstream of the PS/2 ASCII decoder. Consumes the one-cycle `ascii`/`ascii_ready` character stream, builds an editable text line with backspace support, and commits it on Enter. The committed line is held frozen for the consumer, such as the passport form logic, until acknowledged. A registered random-access read port serves the character display.

## Interface
- `MAX_LEN`, 16: line capacity in characters; must be ≥2.
- `AW`, $clog2(MAX_LEN): read-address width.
- `LW`, $clog2(MAX_LEN+1): length width.

Ports:
- `clock_27mhz` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ascii` in 8: character code from the decoder.
- `ascii_ready` in 1: one-cycle strobe; `ascii` is valid while it is high.
- `line_ack` in 1: consumer has taken the committed line.
- `clear` in 1: discards the line being edited.
- `rd_addr` in AW: display read address.
- `rd_data` out 8: character at `rd_addr`, registered.
- `line_flat` out 8*MAX_LEN: char i at bits [8i+7:8i]; unused positions read 0x20.
- `length` out LW: current character count.
- `line_valid` out 1: committed line available; held until ack.
- `full` out 1: `length == MAX_LEN`.
- `dropped` out 1: one-cycle pulse when a printable char is rejected.

## Operation
- Storage is MAX_LEN × 8-bit registers `buf`, plus `length`.
- State machine has two states:
  - EDIT: accepts edits.
  - DONE: line committed, `line_valid` = 1, buffer frozen.
- In EDIT, each `ascii_ready` is classified by `ascii`:
  - 0x08 backspace: if `length` > 0, `buf[length-1]` ← 0x20 and `length`−1. Otherwise no-op.
  - 0x0D enter: if `length` > 0, go to DONE. Otherwise no-op; empty lines are never committed.
  - 0x23 is the decoder's unknown-key marker. Ignore it silently, with no `dropped` pulse.
  - 0x20–0x5F except 0x23 is printable: if `length` < MAX_LEN, `buf[length]` ← `ascii` and `length`+1. If full, discard the char and pulse `dropped`.
  - Any other code: ignore, no pulse.
- `clear` in EDIT: all `buf` ← 0x20, `length` ← 0. `clear` wins over a same-cycle `ascii_ready`, and that char is discarded without a `dropped` pulse.
- In DONE:
  - Printable `ascii_ready` pulses `dropped`. Backspace, enter and other codes are ignored.
  - `line_ack` or `clear` → EDIT, with `buf` all 0x20 and `length` 0. A same-cycle printable char is discarded with a `dropped` pulse.
- `line_ack` in EDIT is ignored.
- `full` is derived from the registered `length`.
- `rd_data` ← `buf[rd_addr]`. If `rd_addr` ≥ MAX_LEN, `rd_data` ← 0x20.

## Timing
- Reset values:
  - state EDIT
  - all `buf` 0x20, so `line_flat` is all 0x20
  - `length` 0
  - `line_valid` 0
  - `full` 0
  - `dropped` 0
  - `rd_data` 0x00
- Reset has priority over every input, including mid-line and in DONE.
- `ascii_ready` high in cycle N updates `buf`, `length`, `full` and `line_flat` at edge N+1.
- Enter in cycle N: `line_valid` = 1 from N+1.
- `line_ack` in cycle M: `line_valid` = 0, `length` = 0 and `line_flat` all 0x20 from M+1. A new char in cycle M+1 is accepted.
- `dropped` is high exactly in cycle N+1 for a rejection in cycle N.
- `rd_data` has 1-cycle latency from `rd_addr`. It reflects `buf` as it stood before the same edge's write.
- Back-to-back `ascii_ready` in consecutive cycles must all be processed. The block needs no stall, since the upstream stage cannot backpressure.

## Test plan
- **Basic entry:** after reset, send 0x41, 0x42, 0x43 → `length` = 3, `line_flat[23:0]` = 0x434241, remaining bytes 0x20, `line_valid` = 0.
- **Backspace:** "AB", 0x08, 0x08, 0x08 → `length` goes 2 → 1 → 0 → 0, `buf[0]` = 0x20, no underflow. Enter at `length` 0 leaves `line_valid` = 0.
- **Overflow:** 17 × 0x31 with MAX_LEN = 16 → `length` = 16, `full` = 1, exactly one `dropped` pulse, and `buf[15]` = 0x31. 0x23 at full gives no pulse.
- **Commit handshake:**
  - "HI", then 0x0D → `line_valid` = 1 the next cycle.
  - 0x58 while DONE → `dropped` pulse, `line_flat[15:0]` stays 0x4948.
  - `line_ack` → `line_valid` = 0 and `length` = 0 one cycle later.
- **Simultaneous events:**
  - `clear` with `ascii_ready` 0x41 in EDIT → `length` 0, no `dropped`.
  - `line_ack` with 0x41 in DONE → EDIT, `length` 0, `dropped` pulse.
- **Read port and reset:**
  - Write "XYZ", `rd_addr` = 2 → `rd_data` = 0x5A one cycle later.
  - `rd_addr` = 5 → 0x20.
  - Assert `reset` in DONE → all outputs return to reset values on the next cycle.
